// File: rtl/exe_muldiv_unit.sv
// Iterative RV64M multiply/divide unit: radix-2^MUL_BITS shift-add multiplier and
// restoring divider sharing one 2*XLEN accumulator, with start/done handshake.
module exe_muldiv_unit #(
    parameter int XLEN     = 64,
    parameter int MUL_BITS = 2
) (
    input  logic            cpu_clk_50M,
    input  logic            cpu_rst_n,
    input  logic            flush_i,
    input  logic            start_i,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int              CW     = $clog2(XLEN + 1);
    localparam logic [CW-1:0]   N_MUL  = CW'(XLEN / MUL_BITS);
    localparam logic [CW-1:0]   N_MULW = CW'(32 / MUL_BITS);
    localparam logic [CW-1:0]   N_DIV  = CW'(XLEN);
    localparam logic [CW-1:0]   N_DIVW = CW'(32);
    localparam logic [XLEN-1:0] MIN_X  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FINISH} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     count, count_nx;
    logic [2*XLEN-1:0] acc, acc_nx;
    logic [XLEN-1:0]   opnd, opnd_nx;
    logic [XLEN-1:0]   res_nx;
    logic [3:0]        op_q;
    logic              neg1_q, neg2_q;

    // Request decode, evaluated against the live inputs in the accept cycle.
    logic            accept, legal, is_w, is_mul, is_rem, sgn1, sgn2;
    logic            a_neg, b_neg, div_zero, div_ovf, go_finish;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, a_res, special_res;

    assign accept = start_i & (state == S_IDLE) & ~flush_i;
    assign legal  = (op_i <= 4'd12);
    assign is_w   = op_i[3];
    assign is_mul = (op_i <= 4'd3) || (op_i == 4'd8);
    assign is_rem = op_i inside {4'd6, 4'd7, 4'd11, 4'd12};
    assign sgn1   = op_i inside {4'd1, 4'd2, 4'd4, 4'd6, 4'd9, 4'd11};
    assign sgn2   = op_i inside {4'd1, 4'd4, 4'd6, 4'd9, 4'd11};

    assign a_ext = is_w ? (sgn1 ? XLEN'($signed(src1_i[31:0])) : XLEN'(src1_i[31:0])) : src1_i;
    assign b_ext = is_w ? (sgn2 ? XLEN'($signed(src2_i[31:0])) : XLEN'(src2_i[31:0])) : src2_i;
    assign a_neg = sgn1 & (is_w ? src1_i[31] : src1_i[XLEN-1]);
    assign b_neg = sgn2 & (is_w ? src2_i[31] : src2_i[XLEN-1]);
    assign a_mag = a_neg ? -a_ext : a_ext;
    assign b_mag = b_neg ? -b_ext : b_ext;
    assign a_res = is_w ? XLEN'($signed(src1_i[31:0])) : src1_i;

    assign div_zero  = is_w ? (src2_i[31:0] == 32'd0) : (src2_i == '0);
    assign div_ovf   = sgn2 & ~is_mul &
                       (is_w ? (src1_i[31:0] == 32'h8000_0000 && src2_i[31:0] == 32'hFFFF_FFFF)
                             : (src1_i == MIN_X && src2_i == '1));
    assign go_finish = ~legal | (~is_mul & (div_zero | div_ovf));

    always_comb begin
        special_res = '0;
        if (legal && div_zero)     special_res = is_rem ? a_res : '1;
        else if (legal && div_ovf) special_res = is_rem ? '0 : a_res;
    end

    // One iteration step of each engine; hi half = partial product / remainder.
    logic [XLEN+MUL_BITS-1:0] mul_sum;
    logic [2*XLEN-1:0]        mul_step, div_step;
    logic [XLEN:0]            div_shift;
    logic [XLEN+1:0]          div_diff;

    assign mul_sum   = {{MUL_BITS{1'b0}}, acc[2*XLEN-1:XLEN]}
                     + ({{MUL_BITS{1'b0}}, opnd} * (XLEN+MUL_BITS)'(acc[MUL_BITS-1:0]));
    assign mul_step  = {mul_sum, acc[XLEN-1:MUL_BITS]};
    assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, opnd};
    assign div_step  = div_diff[XLEN+1] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                        : {div_diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};

    // Final sign fix-up, taken from the last step so result_o loads as done_o rises.
    logic              w_q, rem_q;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   mul_res, quo, rem, div_val, div_res;

    assign w_q    = op_q[3];
    assign rem_q  = op_q inside {4'd6, 4'd7, 4'd11, 4'd12};
    // A W product sits XLEN-32 bits up in the accumulator after 32/MUL_BITS steps.
    assign prod    = w_q ? (mul_step >> (XLEN - 32)) : mul_step;
    assign prod_s  = (neg1_q ^ neg2_q) ? -prod : prod;
    assign mul_res = w_q ? XLEN'($signed(prod_s[31:0]))
                   : (op_q == 4'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    assign quo     = div_step[XLEN-1:0];
    assign rem     = div_step[2*XLEN-1:XLEN];
    assign div_val = rem_q ? (neg1_q ? -rem : rem) : ((neg1_q ^ neg2_q) ? -quo : quo);
    assign div_res = w_q ? XLEN'($signed(div_val[31:0])) : div_val;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_nx = state;
        count_nx = count;
        acc_nx   = acc;
        opnd_nx  = opnd;
        res_nx   = result_o;
        unique case (state)
            S_IDLE: if (accept) begin
                if (go_finish) begin
                    state_nx = S_FINISH;
                    res_nx   = special_res;
                end else if (is_mul) begin
                    state_nx = S_MUL;
                    count_nx = is_w ? N_MULW : N_MUL;
                    acc_nx   = {{XLEN{1'b0}}, b_mag};
                    opnd_nx  = a_mag;
                end else begin
                    state_nx = S_DIV;
                    count_nx = is_w ? N_DIVW : N_DIV;
                    acc_nx   = {{XLEN{1'b0}}, (is_w ? (a_mag << (XLEN - 32)) : a_mag)};
                    opnd_nx  = b_mag;
                end
            end
            S_MUL: begin
                acc_nx   = mul_step;
                count_nx = count - CW'(1);
                if (count == CW'(1)) begin
                    state_nx = S_FINISH;
                    res_nx   = mul_res;
                end
            end
            S_DIV: begin
                acc_nx   = div_step;
                count_nx = count - CW'(1);
                if (count == CW'(1)) begin
                    state_nx = S_FINISH;
                    res_nx   = div_res;
                end
            end
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
        if (flush_i) begin
            state_nx = S_IDLE;
            res_nx   = result_o;
        end
    end

    // NOTE: the datapath registers are reset too, so no state survives a mid-operation reset.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state    <= S_IDLE;
            count    <= '0;
            acc      <= '0;
            opnd     <= '0;
            op_q     <= '0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            done_o   <= 1'b0;
            result_o <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state    <= state_nx;
            count    <= count_nx;
            acc      <= acc_nx;
            opnd     <= opnd_nx;
            done_o   <= (state_nx == S_FINISH);
            result_o <= res_nx;
            if (accept) begin
                op_q   <= op_i;
                neg1_q <= a_neg;
                neg2_q <= b_neg;
            end
        end
    end

    assign ready_o = (state == S_IDLE);
    assign busy_o  = ~ready_o;

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Self-checking bench for exe_muldiv_unit: scoreboard of expected results and
// done cycles, directed corner cases, randomized ops and flush/reset scenarios.
module tb_exe_muldiv_unit;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op    = '0;
    logic [63:0] src1  = '0;
    logic [63:0] src2  = '0;
    logic        ready, busy, done;
    logic [63:0] result;

    exe_muldiv_unit #(.XLEN(64), .MUL_BITS(2)) dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .flush_i     (flush),
        .start_i     (start),
        .op_i        (op),
        .src1_i      (src1),
        .src2_i      (src2),
        .ready_o     (ready),
        .busy_o      (busy),
        .done_o      (done),
        .result_o    (result)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] last_exp = '0;

    logic [63:0] exp_res_q[$];
    int          exp_cyc_q[$];
    string       exp_tag_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    // Reference model written directly from the ISA semantics.
    function automatic logic [63:0] model(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
        logic [127:0]       p;
        logic signed [63:0] sa, sb;
        logic signed [31:0] wa, wb;
        logic [31:0]        w;
        sa = a; sb = b; wa = a[31:0]; wb = b[31:0];
        case (o)
            4'd0: begin p = {64'd0, a} * {64'd0, b}; return p[63:0]; end
            4'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
            4'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; return p[127:64]; end
            4'd3: begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
            4'd4: begin
                if (b == 0) return '1;
                if (a == MIN64 && b == '1) return a;
                return 64'(sa / sb);
            end
            4'd5: return (b == 0) ? '1 : a / b;
            4'd6: begin
                if (b == 0) return a;
                if (a == MIN64 && b == '1) return '0;
                return 64'(sa % sb);
            end
            4'd7: return (b == 0) ? a : a % b;
            4'd8: begin w = a[31:0] * b[31:0]; return 64'($signed(w)); end
            4'd9: begin
                if (b[31:0] == 0) w = '1;
                else if (a[31:0] == 32'h8000_0000 && b[31:0] == '1) w = a[31:0];
                else w = 32'(wa / wb);
                return 64'($signed(w));
            end
            4'd10: begin w = (b[31:0] == 0) ? '1 : a[31:0] / b[31:0]; return 64'($signed(w)); end
            4'd11: begin
                if (b[31:0] == 0) w = a[31:0];
                else if (a[31:0] == 32'h8000_0000 && b[31:0] == '1) w = '0;
                else w = 32'(wa % wb);
                return 64'($signed(w));
            end
            4'd12: begin w = (b[31:0] == 0) ? a[31:0] : a[31:0] % b[31:0]; return 64'($signed(w)); end
            default: return '0;
        endcase
    endfunction

    // Cycle (relative to accept) in which done_o is expected.
    function automatic int lat(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
        if (o > 4'd12) return 1;
        if (o <= 4'd3) return 33;
        if (o == 4'd8) return 17;
        if (o <= 4'd7) begin
            if (b == 0 || ((o == 4'd4 || o == 4'd6) && a == MIN64 && b == '1)) return 1;
            return 65;
        end
        if (b[31:0] == 0 || ((o == 4'd9 || o == 4'd11) && a[31:0] == 32'h8000_0000 && b[31:0] == '1))
            return 1;
        return 33;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (exp_res_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                check({exp_tag_q[0], "_result"}, result, exp_res_q[0]);
                check({exp_tag_q[0], "_cycle"}, 64'(cyc), 64'(exp_cyc_q[0]));
                last_exp <= exp_res_q[0];
                exp_res_q.delete(0);
                exp_cyc_q.delete(0);
                exp_tag_q.delete(0);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic tick_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic push(input logic [63:0] res, input int at, input string tag);
        exp_res_q.push_back(res);
        exp_cyc_q.push_back(at);
        exp_tag_q.push_back(tag);
    endtask

    task automatic wait_drain(input string tag);
        int t = 0;
        while (exp_res_q.size() != 0 && t < 300) begin
            tick();
            t++;
        end
        if (exp_res_q.size() != 0) begin
            check({tag, "_done_timeout"}, 64'd0, 64'd1);
            exp_res_q.delete();
            exp_cyc_q.delete();
            exp_tag_q.delete();
        end
    endtask

    // Issue one op, scramble the inputs after accept, wait for its result.
    task automatic issue(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input string tag);
        int t = 0;
        while (ready !== 1'b1 && t < 300) begin
            tick();
            t++;
        end
        if (ready !== 1'b1) check({tag, "_ready_timeout"}, 64'd0, 64'd1);
        op = o; src1 = a; src2 = b; start = 1'b1;
        push(exp, cyc + lat(o, a, b), tag);
        tick();
        start = 1'b0;
        op    = 4'($urandom_range(0, 15));
        src1  = {$urandom, $urandom};
        src2  = {$urandom, $urandom};
        wait_drain(tag);
        tick();
        check({tag, "_ready_after"}, 64'(ready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  o;
        logic [63:0] a, b;
        int          c;

        repeat (3) @(negedge clk);
        #1;
        check("reset_ready", 64'(ready), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", result, 64'd0);
        rst_n = 1'b1;
        tick();

        issue(4'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, "mul_3x-5");
        issue(4'd4, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, "div_7_-2");
        issue(4'd6, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, "rem_7_-2");
        issue(4'd7, 64'd7, 64'd2, 64'd1, "remu_7_2");
        issue(4'd5, 64'h0123_4567_89AB_CDEF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, "divu_by0");
        issue(4'd6, 64'h0123_4567_89AB_CDEF, 64'd0, 64'h0123_4567_89AB_CDEF, "rem_by0");
        issue(4'd4, MIN64, 64'hFFFF_FFFF_FFFF_FFFF, MIN64, "div_ovf");
        issue(4'd6, MIN64, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, "rem_ovf");
        issue(4'd9, 64'h1234_5678_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, "divw_ovf");
        issue(4'd10, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, "divuw_sext");
        issue(4'd3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, "mulhu_ones");
        issue(4'd2, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, "mulhsu_-1x2");
        issue(4'd8, 64'hDEAD_0000_0001_0000, 64'h0000_0000_0001_0001, 64'h0000_0000_0001_0000, "mulw");
        issue(4'd14, 64'd5, 64'd6, 64'd0, "illegal");

        for (int i = 0; i < 24; i++) begin
            o = 4'($urandom_range(0, 15));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i % 3 == 0) b = 64'($urandom_range(0, 5));
            if (i % 4 == 1) b = -b;
            if (i % 5 == 2) a = 64'($urandom_range(0, 1000));
            issue(o, a, b, model(o, a, b), $sformatf("rnd%0d_op%0d", i, o));
        end

        // Flush in cycle 10 of a DIV: no done, idle next cycle, result kept.
        c = cyc; op = 4'd4; src1 = 64'd1000; src2 = 64'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick_to(c + 10);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_div_ready", 64'(ready), 64'd1);
        check("flush_div_result", result, last_exp);
        repeat (70) tick();
        check("flush_div_result_later", result, last_exp);
        issue(4'd0, 64'd2, 64'd3, 64'd6, "mul_after_flush");

        // Flush together with start: request dropped.
        op = 4'd0; src1 = 64'd9; src2 = 64'd9; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        check("flush_start_ready", 64'(ready), 64'd1);
        check("flush_start_busy", 64'(busy), 64'd0);
        repeat (40) tick();
        check("flush_start_result", result, last_exp);

        // Flush in the FINISH cycle: done still pulses.
        c = cyc; op = 4'd0; src1 = 64'd5; src2 = 64'd7; start = 1'b1;
        push(64'd35, c + 33, "mul_flush_finish");
        tick();
        start = 1'b0;
        tick_to(c + 33);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_finish_drained", 64'(exp_res_q.size()), 64'd0);
        check("flush_finish_ready", 64'(ready), 64'd1);
        wait_drain("mul_flush_finish");

        // Start held through FINISH: second op accepted the cycle after.
        c = cyc; op = 4'd8; src1 = 64'd6; src2 = 64'd7; start = 1'b1;
        push(64'd42, c + 17, "b2b_mulw");
        push(64'd14, c + 18 + 65, "b2b_divu");
        tick();
        op = 4'd5; src1 = 64'd100; src2 = 64'd7;
        tick_to(c + 19);
        start = 1'b0;
        wait_drain("b2b");
        tick();

        // Reset in the middle of a MUL.
        c = cyc; op = 4'd0; src1 = 64'd11; src2 = 64'd13; start = 1'b1;
        tick();
        start = 1'b0;
        tick_to(c + 10);
        rst_n = 1'b0;
        #1;
        check("midreset_result", result, 64'd0);
        check("midreset_ready", 64'(ready), 64'd1);
        check("midreset_done", 64'(done), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (40) tick();
        check("midreset_idle", 64'(busy), 64'd0);
        issue(4'd1, MIN64, MIN64, 64'h4000_0000_0000_0000, "mulh_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
